// File: rtl/frame_pkg.sv
// Symbol codes and state encoding shared by the transmit framing sequencer.
package frame_pkg;

  localparam logic [7:0] K_IDLE  = 8'hBC;  // K28.5, also used as underrun fill
  localparam logic [7:0] K_SOF   = 8'hFB;  // K27.7
  localparam logic [7:0] K_EOF   = 8'hFD;  // K29.7
  localparam logic [7:0] K_ABORT = 8'hFE;  // K30.7

  localparam int CRC_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    SOF,
    DATA,
    CRC,
    EOF,
    IFG,
    ABORT
  } state_t;

endpackage

// File: rtl/frame_tx_seq.sv
// Transmit framing sequencer: wraps a valid/ready/last payload stream into
// SOF / payload / CRC32 (LSB first) / EOF / inter-frame gap symbols.
module frame_tx_seq
  import frame_pkg::*;
#(
  parameter int IFG_CYCLES = 12,
  parameter int MAX_LEN    = 1518,
  parameter int LEN_W      = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  crc_data,
  output logic        crc_valid,
  output logic        crc_is_s1data,
  input  logic [31:0] crc_result,
  output logic [7:0]  tx_byte,
  output logic        tx_is_k,
  output logic        tx_valid,
  output logic        abort_pulse
);

  localparam int IFG_W = $clog2(IFG_CYCLES + 1);

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic [IFG_W-1:0] r_ifg;
  logic [1:0]       r_crc_idx;
  logic [23:0]      r_crc_sh;
  logic [7:0]       r_tx_byte;
  logic             r_tx_is_k;
  logic             r_tx_valid;
  logic             r_abort;

  logic             w_accept;
  logic [LEN_W-1:0] w_len_next;

  // Handshake and crc32 controls depend on state only, so in_ready never
  // combinationally depends on in_valid.
  assign in_ready      = (r_state == DATA);
  assign crc_data      = in_data;
  assign crc_valid     = in_valid & in_ready;
  assign crc_is_s1data = (r_state == DATA);

  assign w_accept   = in_valid & in_ready;
  assign w_len_next = r_len + 1'b1;

  // NOTE: state and every output register share one async-reset block with
  // non-blocking assignments; r_crc_sh is reset too so a reset mid-trailer
  // leaves nothing stale behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_ifg      <= '0;
      r_crc_idx  <= '0;
      r_crc_sh   <= '0;
      r_tx_byte  <= K_IDLE;
      r_tx_is_k  <= 1'b1;
      r_tx_valid <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_tx_valid <= 1'b1;
      r_abort    <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_tx_byte <= K_IDLE;
          r_tx_is_k <= 1'b1;
          if (in_valid) r_state <= SOF;
        end
        SOF: begin
          r_tx_byte <= K_SOF;
          r_tx_is_k <= 1'b1;
          r_len     <= '0;
          r_crc_idx <= '0;
          r_state   <= DATA;
        end
        DATA: begin
          if (w_accept) begin
            r_tx_byte <= in_data;
            r_tx_is_k <= 1'b0;
            r_len     <= w_len_next;
            if (in_last)                               r_state <= CRC;
            else if (w_len_next == LEN_W'(MAX_LEN))    r_state <= ABORT;
          end else begin
            r_tx_byte <= K_IDLE;
            r_tx_is_k <= 1'b1;
          end
        end
        CRC: begin
          r_tx_is_k <= 1'b0;
          // crc32 reloads at the first trailer edge, so its result is captured once.
          if (r_crc_idx == 2'd0) begin
            r_tx_byte <= crc_result[7:0];
            r_crc_sh  <= crc_result[31:8];
          end else begin
            r_tx_byte <= r_crc_sh[7:0];
            r_crc_sh  <= {8'h00, r_crc_sh[23:8]};
          end
          r_crc_idx <= r_crc_idx + 2'd1;
          if (r_crc_idx == 2'(CRC_BYTES - 1)) r_state <= EOF;
        end
        EOF: begin
          r_tx_byte <= K_EOF;
          r_tx_is_k <= 1'b1;
          r_ifg     <= IFG_W'(IFG_CYCLES);
          r_state   <= IFG;
        end
        IFG: begin
          r_tx_byte <= K_IDLE;
          r_tx_is_k <= 1'b1;
          r_ifg     <= r_ifg - 1'b1;
          if (r_ifg == IFG_W'(1)) r_state <= IDLE;
        end
        ABORT: begin
          r_tx_byte <= K_ABORT;
          r_tx_is_k <= 1'b1;
          r_abort   <= 1'b1;
          r_ifg     <= IFG_W'(IFG_CYCLES);
          r_state   <= IFG;
        end
        default: begin
          r_tx_byte <= K_IDLE;
          r_tx_is_k <= 1'b1;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign tx_byte     = r_tx_byte;
  assign tx_is_k     = r_tx_is_k;
  assign tx_valid    = r_tx_valid;
  assign abort_pulse = r_abort;

endmodule

// File: tb/tb_frame_tx_seq.sv
// Bench for frame_tx_seq: crc32 stand-in, stream driver and a frame-level
// reference model that predicts the whole symbol stream from the payload plan.
module tb_frame_tx_seq;

  localparam int IFG_CYCLES = 12;
  localparam int MAX_LEN    = 16;
  localparam int LEN_W      = 5;

  localparam logic [7:0] K_IDLE  = 8'hBC;
  localparam logic [7:0] K_SOF   = 8'hFB;
  localparam logic [7:0] K_EOF   = 8'hFD;
  localparam logic [7:0] K_ABORT = 8'hFE;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  crc_data;
  logic        crc_valid;
  logic        crc_is_s1data;
  logic [31:0] crc_result;
  logic [7:0]  tx_byte;
  logic        tx_is_k;
  logic        tx_valid;
  logic        abort_pulse;

  frame_tx_seq #(.IFG_CYCLES(IFG_CYCLES), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .crc_data(crc_data), .crc_valid(crc_valid), .crc_is_s1data(crc_is_s1data),
    .crc_result(crc_result),
    .tx_byte(tx_byte), .tx_is_k(tx_is_k), .tx_valid(tx_valid), .abort_pulse(abort_pulse)
  );

  always #5 clk = ~clk;

  // Reflected CRC-32 (poly 04C11DB7), init all-ones, output inverted.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] crc32_of(input logic [7:0] q[$]);
    logic [31:0] c;
    c = '1;
    foreach (q[i]) c = crc_step(c, q[i]);
    return ~c;
  endfunction

  // Stand-in for the neighbouring crc32 block.
  logic [31:0] crc_reg;
  always @(posedge clk or posedge rst) begin
    if (rst)                 crc_reg <= '1;
    else if (!crc_is_s1data) crc_reg <= '1;
    else if (crc_valid)      crc_reg <= crc_step(crc_reg, crc_data);
  end
  assign crc_result = ~crc_reg;

  typedef struct packed {
    logic       v;
    logic       k;
    logic [7:0] b;
    logic       ab;
    logic       rdy;
  } obs_t;

  typedef struct packed {
    logic       k;
    logic [7:0] b;
    logic       ab;
    logic       dat;   // symbol produced while the sequencer sat in the payload phase
  } exp_t;

  obs_t       obs_q[$];
  exp_t       exp_q[$];
  logic [7:0] sd[$];
  logic       sl[$];
  int         sg[$];
  int         sidx;
  int         gap_rem;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic clear_stim();
    sd.delete(); sl.delete(); sg.delete();
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l, input int g);
    sd.push_back(d); sl.push_back(l); sg.push_back(g);
  endtask

  // One cycle: sample outputs at negedge, then present the next input.
  task automatic drive_cycle();
    obs_t o;
    @(negedge clk);
    o.v = tx_valid; o.k = tx_is_k; o.b = tx_byte; o.ab = abort_pulse; o.rdy = in_ready;
    obs_q.push_back(o);
    if (sidx < sd.size()) begin
      if (in_ready && gap_rem > 0) begin
        in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
        gap_rem--;
      end else begin
        in_valid = 1'b1; in_data = sd[sidx]; in_last = sl[sidx];
        if (in_ready) begin
          sidx++;
          gap_rem = (sidx < sd.size()) ? sg[sidx] : 0;
        end
      end
    end else begin
      in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
    end
  endtask

  // Frame-level model: payload plan -> expected symbol stream from the first SOF.
  task automatic build_expected();
    logic [7:0]  fr[$];
    logic [31:0] c;
    exp_q.delete();
    exp_q.push_back({1'b1, K_SOF, 1'b0, 1'b0});
    for (int i = 0; i < sd.size(); i++) begin
      for (int g = 0; g < sg[i]; g++) exp_q.push_back({1'b1, K_IDLE, 1'b0, 1'b1});
      exp_q.push_back({1'b0, sd[i], 1'b0, 1'b1});
      fr.push_back(sd[i]);
      if (sl[i] || fr.size() == MAX_LEN) begin
        if (sl[i]) begin
          c = crc32_of(fr);
          for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, c[8*k +: 8], 1'b0, 1'b0});
          exp_q.push_back({1'b1, K_EOF, 1'b0, 1'b0});
        end else begin
          exp_q.push_back({1'b1, K_ABORT, 1'b1, 1'b0});
        end
        for (int g = 0; g < IFG_CYCLES; g++) exp_q.push_back({1'b1, K_IDLE, 1'b0, 1'b0});
        fr.delete();
        if (i < sd.size() - 1) begin
          exp_q.push_back({1'b1, K_IDLE, 1'b0, 1'b0});
          exp_q.push_back({1'b1, K_SOF, 1'b0, 1'b0});
        end
      end
    end
    exp_q.push_back({1'b1, K_IDLE, 1'b0, 1'b0});
    exp_q.push_back({1'b1, K_IDLE, 1'b0, 1'b0});
  endtask

  task automatic compare_stream(input string tag, output int a);
    exp_t e;
    obs_t o;
    a = -1;
    for (int i = 0; i < obs_q.size(); i++)
      if (obs_q[i].k && obs_q[i].b == K_SOF) begin a = i; break; end
    n_cmp++;
    if (a != 2) begin
      n_bad++;
      $display("FAIL %s sof_latency: first SOF at sample %0d, required 2", tag, a);
    end
    if (a < 1) return;
    for (int i = 0; i < a; i++) begin
      o = obs_q[i];
      n_cmp++;
      if ({o.v, o.k, o.b, o.ab, o.rdy} !== {1'b1, 1'b1, K_IDLE, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL %s pre_sof[%0d]: got v%b k%b %h ab%b rdy%b, required v1 k1 bc ab0 rdy0",
                 tag, i, o.v, o.k, o.b, o.ab, o.rdy);
        break;
      end
    end
    for (int j = 0; j < exp_q.size(); j++) begin
      e = exp_q[j];
      n_cmp++;
      if (a + j >= obs_q.size()) begin
        n_bad++;
        $display("FAIL %s stream_short: stopped at symbol %0d of %0d", tag, j, exp_q.size());
        break;
      end
      o = obs_q[a + j];
      if ({o.v, o.k, o.b, o.ab} !== {1'b1, e.k, e.b, e.ab} || obs_q[a + j - 1].rdy !== e.dat) begin
        n_bad++;
        $display("FAIL %s sym[%0d]: got v%b k%b %h ab%b rdy_prev%b, required v1 k%b %h ab%b rdy_prev%b",
                 tag, j, o.v, o.k, o.b, o.ab, obs_q[a + j - 1].rdy, e.k, e.b, e.ab, e.dat);
        break;
      end
    end
  endtask

  task automatic run_and_compare(input string tag, output int a);
    build_expected();
    obs_q.delete();
    sidx    = 0;
    gap_rem = (sg.size() > 0) ? sg[0] : 0;
    repeat (exp_q.size() + 4) drive_cycle();
    compare_stream(tag, a);
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({tx_byte, tx_is_k, tx_valid, abort_pulse, in_ready, crc_valid, crc_is_s1data} !==
        {K_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_values: got tx %h k%b v%b ab%b rdy%b cv%b s1%b, required bc k1 v0 ab0 rdy0 cv0 s1 0",
               tx_byte, tx_is_k, tx_valid, abort_pulse, in_ready, crc_valid, crc_is_s1data);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({tx_byte, tx_is_k, tx_valid, crc_data} !== {K_IDLE, 1'b1, 1'b0, 8'h5A}) begin
      n_bad++;
      $display("FAIL reset_hold: got tx %h k%b v%b crc_data %h, required bc k1 v0 5a",
               tx_byte, tx_is_k, tx_valid, crc_data);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_known_vector();
    logic [7:0] ref_crc [4] = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    int a;
    clear_stim();
    for (int i = 0; i < 9; i++) push_byte(8'h31 + 8'(i), i == 8, 0);
    run_and_compare("known_123456789", a);
    if (a < 0 || a + 14 >= obs_q.size()) return;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (obs_q[a + 10 + k].b !== ref_crc[k]) begin
        n_bad++;
        $display("FAIL known_crc_byte%0d: got %h, required %h", k, obs_q[a + 10 + k].b, ref_crc[k]);
      end
    end
    n_cmp++;
    if ({obs_q[a + 14].k, obs_q[a + 14].b} !== {1'b1, K_EOF}) begin
      n_bad++;
      $display("FAIL known_eof: got k%b %h, required k1 fd", obs_q[a + 14].k, obs_q[a + 14].b);
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] ref_crc [4] = '{8'h8D, 8'hEF, 8'h02, 8'hD2};
    int a;
    clear_stim();
    push_byte(8'h00, 1'b1, 0);
    run_and_compare("single_byte", a);
    if (a < 0 || a + 6 >= obs_q.size()) return;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (obs_q[a + 2 + k].b !== ref_crc[k]) begin
        n_bad++;
        $display("FAIL single_crc_byte%0d: got %h, required %h", k, obs_q[a + 2 + k].b, ref_crc[k]);
      end
    end
  endtask

  task automatic test_underrun();
    logic [7:0] ref_crc [4] = '{8'hA3, 8'hE0, 8'hE3, 8'h9B};
    int a;
    clear_stim();
    push_byte(8'h31, 1'b0, 0);
    push_byte(8'h32, 1'b0, 0);
    push_byte(8'h33, 1'b0, 3);
    push_byte(8'h34, 1'b1, 0);
    run_and_compare("underrun", a);
    if (a < 0 || a + 11 >= obs_q.size()) return;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({obs_q[a + 3 + k].k, obs_q[a + 3 + k].b} !== {1'b1, K_IDLE}) begin
        n_bad++;
        $display("FAIL underrun_fill%0d: got k%b %h, required k1 bc", k, obs_q[a + 3 + k].k, obs_q[a + 3 + k].b);
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (obs_q[a + 8 + k].b !== ref_crc[k]) begin
        n_bad++;
        $display("FAIL underrun_crc_byte%0d: got %h, required %h", k, obs_q[a + 8 + k].b, ref_crc[k]);
      end
    end
  endtask

  task automatic test_abort();
    int a;
    int pulses;
    clear_stim();
    for (int i = 0; i < MAX_LEN + 1; i++) push_byte(8'($urandom), i == MAX_LEN, 0);
    run_and_compare("abort", a);
    pulses = 0;
    foreach (obs_q[i]) if (obs_q[i].ab) pulses++;
    n_cmp++;
    if (pulses != 1) begin
      n_bad++;
      $display("FAIL abort_pulse_count: got %0d, required 1", pulses);
    end
    if (a < 0 || a + MAX_LEN + 1 >= obs_q.size()) return;
    n_cmp++;
    if ({obs_q[a + MAX_LEN + 1].k, obs_q[a + MAX_LEN + 1].b, obs_q[a + MAX_LEN].rdy} !== {1'b1, K_ABORT, 1'b0}) begin
      n_bad++;
      $display("FAIL abort_symbol: got k%b %h rdy%b, required k1 fe rdy0",
               obs_q[a + MAX_LEN + 1].k, obs_q[a + MAX_LEN + 1].b, obs_q[a + MAX_LEN].rdy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int  s;
    int  a;
    bit  hit;
    clear_stim();
    for (int i = 0; i < 3; i++) push_byte(8'($urandom), i == 2, 0);
    obs_q.delete();
    sidx = 0; gap_rem = 0; s = -1; hit = 0;
    for (int c = 0; c < 30; c++) begin
      drive_cycle();
      if (s < 0 && obs_q[$].k && obs_q[$].b == K_SOF) s = obs_q.size() - 1;
      if (s >= 0 && obs_q.size() - 1 == s + 5) begin hit = 1; break; end
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL midreset_reach_crc2: got sof at %0d, required trailer cycle 2 within 30 cycles", s);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({tx_byte, tx_is_k, tx_valid, abort_pulse, in_ready} !== {K_IDLE, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL midreset_values: got tx %h k%b v%b ab%b rdy%b, required bc k1 v0 ab0 rdy0",
               tx_byte, tx_is_k, tx_valid, abort_pulse, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_stim();
    push_byte(8'h31, 1'b0, 0);
    push_byte(8'h32, 1'b1, 1);
    run_and_compare("after_midreset", a);
  endtask

  task automatic test_back_to_back();
    int a;
    int f;
    int g;
    int n;
    clear_stim();
    for (int fr = 0; fr < 2; fr++) begin
      n = 1 + int'($urandom_range(0, 5));
      for (int i = 0; i < n; i++) push_byte(8'($urandom), i == n - 1, 0);
    end
    run_and_compare("back_to_back", a);
    f = -1; g = -1;
    for (int i = (a < 0 ? 0 : a); i < obs_q.size(); i++) begin
      if (f < 0 && obs_q[i].k && obs_q[i].b == K_EOF) f = i;
      else if (f >= 0 && obs_q[i].k && obs_q[i].b == K_SOF) begin g = i; break; end
    end
    n_cmp++;
    if (f < 0 || g < 0 || g - f != IFG_CYCLES + 2) begin
      n_bad++;
      $display("FAIL b2b_spacing: got eof at %0d sof at %0d, required distance %0d", f, g, IFG_CYCLES + 2);
    end
  endtask

  task automatic test_random();
    int a;
    int chunks;
    int n;
    for (int it = 0; it < 8; it++) begin
      clear_stim();
      chunks = 1 + int'($urandom_range(0, 2));
      for (int c = 0; c < chunks; c++) begin
        case ($urandom_range(0, 4))
          0:       n = MAX_LEN;
          1:       n = MAX_LEN + 1 + int'($urandom_range(0, 2));
          default: n = 1 + int'($urandom_range(0, MAX_LEN - 1));
        endcase
        for (int i = 0; i < n; i++)
          push_byte(8'($urandom), i == n - 1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
      run_and_compare($sformatf("random%0d", it), a);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    sidx = 0; gap_rem = 0;
    test_reset();
    test_known_vector();
    test_single_byte();
    test_underrun();
    test_abort();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_tx_seq.md
Name: frame_tx_seq

Overview:
- Transmit framing sequencer. It sits upstream of the existing crc32 block and upstream of the 8b/10b encoder.
- Accepts a byte-stream payload using a valid/ready/last handshake.
- Emits one symbol per clock to the encoder: comma idles, SOF, payload, 4-byte CRC (LSB first), EOF, then inter-frame gap.
- Drives the crc32 block's byte/valid/is_S1DATA inputs and captures its 32-bit result for the trailer.

Parameters:
- IFG_CYCLES, 12, number of idle symbols forced after EOF or abort.
- MAX_LEN, 1518, maximum payload bytes per frame; one more byte without last triggers abort.
- LEN_W, 11, payload length counter width; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  8  payload byte.
- in_valid  input  1  payload byte available.
- in_last  input  1  qualifies in_data as the final payload byte.
- in_ready  output  1  payload byte accepted when in_valid & in_ready.
- crc_data  output  8  byte to crc32 (crc32_in).
- crc_valid  output  1  to crc32 valid.
- crc_is_s1data  output  1  to crc32 is_S1DATA.
- crc_result  input  32  crc32_out from crc32 (already inverted).
- tx_byte  output  8  symbol to encoder.
- tx_is_k  output  1  1 = control symbol.
- tx_valid  output  1  symbol valid.
- abort_pulse  output  1  one-cycle pulse on frame abort.

Behaviour:
- Reset is asynchronous and active-high; one clock, clk.
- Reset values: state IDLE, tx_byte 8'hBC (K28.5), tx_is_k 1, tx_valid 0, abort_pulse 0, length counter 0, IFG counter 0.
- tx_* outputs are registered and reflect the state of the previous cycle. After reset, tx_valid is 1 on every cycle.
- Combinational outputs:
  - in_ready = (state==DATA).
  - crc_data = in_data.
  - crc_valid = in_valid & in_ready.
  - crc_is_s1data = (state==DATA).
- Symbol codes:
  - IDLE/fill K28.5 = 8'hBC.
  - SOF K27.7 = 8'hFB.
  - EOF K29.7 = 8'hFD.
  - ABORT K30.7 = 8'hFE.
- States and transitions:
  - IDLE: emit K28.5. If in_valid=1, go to SOF. No byte is consumed.
  - SOF: emit 8'hFB for exactly 1 cycle, clear the length counter, go to DATA.
  - DATA:
    - On accept: emit in_data with is_k=0 and increment the length counter.
    - If no byte is offered (in_valid=0, underrun): emit fill K28.5. No CRC update; the frame continues.
    - If the accepted byte has in_last=1: go to CRC.
    - If the accepted byte has in_last=0 and the counter reaches MAX_LEN: abort.
  - CRC: 4 cycles, driven by a 2-bit index.
    - Cycle 0: emit crc_result[7:0] and latch crc_result[31:8] into a shift register. crc32 reloads to FFFFFFFF at this edge because crc_is_s1data=0.
    - Cycles 1–3: emit bits [15:8], [23:16], [31:24] from the shift register, all with is_k=0.
    - Then go to EOF.
  - EOF: emit 8'hFD for 1 cycle, load the IFG counter, go to IFG.
  - IFG: emit K28.5 for IFG_CYCLES cycles and ignore in_valid. Then go to IDLE.
  - ABORT: emit 8'hFE for 1 cycle and pulse abort_pulse. No CRC or EOF is sent; go to IFG.
- Latency: payload byte accepted at edge N appears on tx_byte after edge N. The minimum frame overhead is SOF + 4 CRC + EOF = 6 symbols.
- Boundaries:
  - in_last on the very first byte gives a legal 1-byte frame.
  - A byte with in_last=1 that is exactly byte MAX_LEN is a normal frame, not an abort.
  - in_last with in_valid=0 is ignored.
  - Back-to-back frames are separated by at least EOF + IFG_CYCLES + 1 IDLE + SOF.
  - Reset mid-frame: outputs return to reset values immediately. No EOF is emitted. The shared rst also clears crc32.

Decomposition:
- Package frame_pkg:
  - K-code constants: K_IDLE, K_SOF, K_EOF, K_ABORT.
  - State enum: IDLE, SOF, DATA, CRC, EOF, IFG, ABORT.
  - CRC byte count 4.
- No sub-module inside this block. crc32 is instantiated beside it in the tx wrapper and wired as above.

Test Plan:
- Frame "123456789" (31..39 hex), in_valid continuous, last on 8'h39 -> tx: FB(k), 31..39, 26 39 F4 CB, FD(k), then 12×BC. crc_result is 32'hCBF43926 at the first CRC cycle.
- Single byte 8'h00 with last -> FB, 00, 8D EF 02 D2, FD. crc32 is back at FFFFFFFF afterwards (its crc32_out reads 32'h00000000).
- Underrun: "1234", in_valid low for 3 cycles between 8'h32 and 8'h33 -> 3×BC(k) are inserted mid-frame. CRC bytes are identical to the continuous case; 32'h9BE3E0A3 is sent as A3 E0 E3 9B.
- MAX_LEN=4, 5 bytes sent without last -> 4 data bytes, then FE(k) and a one-cycle abort_pulse, then 12 idles. The 5th byte is not accepted (in_ready=0).
- rst asserted during CRC cycle 2 -> tx_byte=BC, tx_is_k=1, tx_valid=0 immediately. After release, the next frame is correct from SOF.
- Two frames back-to-back with in_valid held high -> second FB appears exactly IFG_CYCLES+2 cycles after the first FD. in_ready stays 0 throughout IFG.
